cache_control_nway: RTL

- Parametrised successor to the two-way cache controller FSM.
- Controls a WAYS-way set-associative, write-back, write-allocate cache.
- Drives multi-beat line write-back and line fill over a per-beat req/ack memory handshake.
- Sits between the CPU load/store interface, the tag/data/metadata arrays, the replacement unit and the memory adapter.
- Purely control: it moves no data, it only produces strobes and selects.

---
 rtl/cache_pkg.sv | 12 +
 rtl/cache_beat_ctr.sv | 41 ++++
 rtl/cache_control_nway.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared state/op types and beat-width helper for the n-way cache controller
package cache_pkg;

  typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, FILL, ERROR} state_e;

  typedef enum logic {RD = 1'b0, WR = 1'b1} op_e;

  function automatic int beat_w(input int line_words);
    return (line_words > 2) ? $clog2(line_words) : 1;
  endfunction

endpackage

// File: rtl/cache_beat_ctr.sv
// rtl/cache_beat_ctr.sv - memory beat counter with clear, increment and last-beat flag
module cache_beat_ctr
  import cache_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int BW = beat_w(LINE_WORDS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  output logic [BW-1:0] cnt,
  output logic          last
);

  localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_WORDS - 1);

  logic [BW-1:0] cnt_q, cnt_d;

  // Explicit wrap on the last beat keeps LINE_WORDS=1 correct as well.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = last ? '0 : cnt_q + BW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign last = (cnt_q == LAST_BEAT);

endmodule

// File: rtl/cache_control_nway.sv
// rtl/cache_control_nway.sv - WAYS-way write-back, write-allocate cache control FSM
// Define CACHE_PERF_CNT_EN to add saturating hit/miss/write-back counters.
module cache_control_nway
  import cache_pkg::*;
#(
  parameter int WAYS       = 2,
  parameter int LINE_WORDS = 4,
  parameter int CNT_W      = 32
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              cpu_read,
  input  logic                              cpu_write,
  output logic                              cpu_ready,
  input  logic                              hit,
  input  logic [WAYS-1:0]                   hit_way,
  input  logic [WAYS-1:0]                   is_valid,
  input  logic [WAYS-1:0]                   is_dirty,
  input  logic [WAYS-1:0]                   victim_way,
  output logic                              repl_update,
  output logic [WAYS-1:0]                   repl_way,
  output logic                              mem_req,
  output logic                              mem_we,
  input  logic                              mem_ack,
  output logic [beat_w(LINE_WORDS)-1:0]     beat_idx,
  output logic [WAYS-1:0]                   fill_we,
  output logic [WAYS-1:0]                   cpu_we,
  output logic [WAYS-1:0]                   tag_we,
  output logic [WAYS-1:0]                   meta_we,
  output logic                              meta_valid,
  output logic                              meta_dirty,
  output logic                              data_in_select,
  output logic                              error
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]                  hit_cnt,
  output logic [CNT_W-1:0]                  miss_cnt,
  output logic [CNT_W-1:0]                  wb_cnt
`endif
);

  localparam int BW = beat_w(LINE_WORDS);

  state_e          state_q, state_d;
  op_e             op_q, op_d;
  logic [WAYS-1:0] victim_q, victim_d;
  logic            cnt_clr, cnt_inc, cnt_last;
  logic [BW-1:0]   cnt;
  logic            hit_onehot, victim_onehot, victim_dirty;

  assign hit_onehot    = (hit_way != '0) && ((hit_way & (hit_way - WAYS'(1))) == '0);
  assign victim_onehot = (victim_way != '0) && ((victim_way & (victim_way - WAYS'(1))) == '0);
  assign victim_dirty  = |(victim_way & is_valid & is_dirty);

  cache_beat_ctr #(
    .LINE_WORDS(LINE_WORDS),
    .BW        (BW)
  ) u_beat_ctr (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (cnt_clr),
    .inc  (cnt_inc),
    .cnt  (cnt),
    .last (cnt_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= RD;
      victim_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      victim_q <= victim_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    victim_d       = victim_q;
    cnt_clr        = 1'b0;
    cnt_inc        = 1'b0;
    cpu_ready      = 1'b0;
    repl_update    = 1'b0;
    repl_way       = '0;
    mem_req        = 1'b0;
    mem_we         = 1'b0;
    beat_idx       = '0;
    fill_we        = '0;
    cpu_we         = '0;
    tag_we         = '0;
    meta_we        = '0;
    meta_valid     = 1'b0;
    meta_dirty     = 1'b0;
    data_in_select = 1'b0;
    error          = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_clr = 1'b1;
        if (cpu_write) begin
          op_d    = WR;
          state_d = LOOKUP;
        end else if (cpu_read) begin
          op_d    = RD;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit) begin
          if (hit_onehot) begin
            repl_update = 1'b1;
            repl_way    = hit_way;
            cpu_ready   = 1'b1;
            if (op_q == WR) begin
              cpu_we     = hit_way;
              meta_we    = hit_way;
              meta_valid = 1'b1;
              meta_dirty = 1'b1;
            end
            state_d = IDLE;
          end else begin
            state_d = ERROR;
          end
        end else if (!victim_onehot) begin
          state_d = ERROR;
        end else begin
          victim_d = victim_way;
          state_d  = victim_dirty ? WRITEBACK : FILL;
        end
      end
      WRITEBACK: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        beat_idx = cnt;
        cnt_inc  = mem_ack;
        if (mem_ack && cnt_last) begin
          state_d = FILL;
        end
      end
      FILL: begin
        mem_req        = 1'b1;
        data_in_select = 1'b1;
        beat_idx       = cnt;
        cnt_inc        = mem_ack;
        if (mem_ack) begin
          fill_we = victim_q;
          // Line becomes valid and clean only once the final beat lands.
          if (cnt_last) begin
            tag_we     = victim_q;
            meta_we    = victim_q;
            meta_valid = 1'b1;
            state_d    = LOOKUP;
          end
        end
      end
      ERROR: begin
        error   = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef CACHE_PERF_CNT_EN
  logic             retry_q, retry_d;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
  logic [CNT_W-1:0] wb_cnt_q, wb_cnt_d;

  // retry_q marks the lookup that follows a fill so its hit is not counted twice.
  always_comb begin
    retry_d    = retry_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    wb_cnt_d   = wb_cnt_q;
    if (state_q == FILL && state_d == LOOKUP) begin
      retry_d = 1'b1;
    end else if (state_q == LOOKUP) begin
      retry_d = 1'b0;
    end
    if (state_q == LOOKUP && hit && hit_onehot && !retry_q && !(&hit_cnt_q)) begin
      hit_cnt_d = hit_cnt_q + CNT_W'(1);
    end
    if (state_q == LOOKUP && !hit && !(&miss_cnt_q)) begin
      miss_cnt_d = miss_cnt_q + CNT_W'(1);
    end
    if (state_q == LOOKUP && state_d == WRITEBACK && !(&wb_cnt_q)) begin
      wb_cnt_d = wb_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retry_q    <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      retry_q    <= retry_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      wb_cnt_q   <= wb_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
  assign wb_cnt   = wb_cnt_q;
`endif

endmodule
